instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the MIPS instruction memory (256 x 32-bit words, word-indexed read port). Holds the PC, issues one word request at a time over a req/ready + rvalid handshake, and buffers returned words with their PC in a small FIFO toward decode. It also accepts branch/jump redirects from execute, flushing queued and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, byte PC loaded at reset.
MEM_AW, 8, word-index width of instruction memory (256 words).
FIFO_DEPTH, 2, fetch buffer entries (power of 2, >=2).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
run  in  1  1 = fetch enabled; 0 = no new requests.
mem_req  out  1  request valid toward instruction memory.
mem_addr  out  MEM_AW  word index = pc_q[MEM_AW+1:2].
mem_ready  in  1  memory accepts request this cycle.
mem_rvalid  in  1  response word valid (in order, >=1 cycle after accept).
mem_rdata  in  32  returned instruction word.
instr_valid  out  1  FIFO head valid.
instr  out  32  FIFO head instruction.
instr_pc  out  32  byte PC of FIFO head.
instr_ready  in  1  decode pops head when instr_valid && instr_ready.
redirect_valid  in  1  branch/jump taken.
redirect_pc  in  32  target byte PC; bits [1:0] forced to 0.

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, state=IDLE, FIFO empty, mem_req=0, instr_valid=0, instr=0, instr_pc=0. Outputs registered/derived from registers only.
- States: IDLE, REQ, WAIT, DROP. Max one outstanding request.
- IDLE -> REQ when run=1 and (fifo_count + 0) < FIFO_DEPTH.
- REQ: mem_req=1, mem_addr from pc_q, held stable until accepted. Accept (mem_req && mem_ready): capture req_pc=pc_q, pc_q+=4 (wraps mod 2^32), -> WAIT.
- WAIT: mem_req=0. On mem_rvalid: push {req_pc, mem_rdata} into FIFO; -> REQ if run=1 and slot free after this push/pop, else IDLE. Earliest back-to-back fetch: one request per 2 cycles at 1-cycle memory latency.
- Space reservation: REQ entered only if fifo_count < FIFO_DEPTH counting the same-cycle pop; push never overflows.
- run=0: no new acceptance starts from IDLE; REQ not yet accepted drops back to IDLE; WAIT completes normally; FIFO still drains.
- Redirect (highest priority): pc_q <= {redirect_pc[31:2],2'b00}; FIFO flushed (instr_valid=0 next cycle); same-cycle pop ignored. If in WAIT, or accept occurs in the redirect cycle -> DROP; else -> REQ (run=1) / IDLE.
- DROP: mem_req=0; next mem_rvalid discarded (no push), then -> REQ/IDLE. Redirect in DROP updates pc_q, stays DROP.
- Redirect with mem_rvalid in same WAIT cycle: response discarded, -> REQ/IDLE (not DROP).
- FIFO: no bypass; pushed word visible on instr outputs the cycle after push. Simultaneous push and pop when count unchanged. Strict in-order.
- mem_addr wraps naturally: pc 0x3FC -> index 255, next 0x400 -> index 0.

Test Plan:
- Reset, run=1, memory latency 1, mem_ready=1, words 8C010000,8C020004,00221820 at idx 0..2, instr_ready=1 -> instr_pc 0,4,8 with matching instr in order, mem_req pulses every 2nd cycle.
- instr_ready=0 -> FIFO holds exactly 2 entries (pc 0,4), mem_req stays 0; raise instr_ready -> pc 0,4,8 delivered in order, no loss or duplicate.
- Redirect redirect_pc=0x18 while WAIT for pc 0x8 -> returned word dropped, FIFO empty, next mem_addr=6, next instr=10620001 with instr_pc=0x18.
- redirect_pc=0x1B in same cycle as instr pop and mem_rvalid -> pop ignored, response dropped, next instr_pc=0x18.
- mem_ready held 0 for 5 cycles -> mem_req and mem_addr stable throughout; run=0 mid-REQ -> mem_req drops next cycle, FIFO drains.
- RESET_PC=0x3FC -> mem_addr 255 then 0; assert rst_n=0 mid-WAIT -> outputs zero immediately, late rvalid after release ignored, fetch restarts at 0x3FC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: single-outstanding word fetch from instruction memory,
// small in-order fetch buffer toward decode, and redirect flushing from execute.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_AW     = 8,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       instr_pc_o,
  input  logic              instr_ready_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_pc_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fentry_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  fentry_t         fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_nx;
  logic            accept, push, pop, space;
  state_t          resume_st;

  assign accept   = (state_q == REQ) && mem_ready_i;
  // A redirect flushes the buffer, so neither the pop nor the returning word may count.
  assign pop      = (count_q != '0) && instr_ready_i && !redirect_valid_i;
  assign push     = (state_q == WAIT) && mem_rvalid_i && !redirect_valid_i;
  assign count_nx = count_q + CW'(push) - CW'(pop);
  assign space    = count_nx < CW'(FIFO_DEPTH);
  // After a flush the buffer is empty, so a new request always has room.
  assign resume_st = (run_i && (redirect_valid_i || space)) ? REQ : IDLE;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (accept) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
    unique case (state_q)
      IDLE: state_d = resume_st;
      REQ:  state_d = accept ? WAIT : resume_st;
      WAIT: begin
        if (mem_rvalid_i)          state_d = resume_st;
        else if (redirect_valid_i) state_d = DROP;
      end
      DROP: if (mem_rvalid_i) state_d = resume_st;
      default: state_d = IDLE;
    endcase
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i & ~32'd3;
      // A request accepted alongside the redirect still returns a word that must be dropped.
      if (accept) state_d = DROP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (redirect_valid_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{pc: req_pc_q, word: mem_rdata_i};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_nx;
    end
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_addr_o    = pc_q[MEM_AW+1:2];
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? fifo_q[rd_ptr_q].word : '0;
  assign instr_pc_o    = instr_valid_o ? fifo_q[rd_ptr_q].pc   : '0;

endmodule
